// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - execute-side branch/JALR resolution and fetch redirect
//
// Takes the conditional branch or JALR that dispatch hands over and waits
// for the branch unit result that carries the same ROB tag. A not-taken
// branch resolves directly. A taken branch or any JALR first raises a
// redirect to fetch, together with a flush of the instruction fetch queue.
// The solved pulse that releases the dispatch stall follows the redirect
// handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   disp_branch, disp_jalr   control instruction dispatched this cycle
//   disp_tag/pc/imm          ROB tag, PC and branch offset of that instruction
//   ex_valid/tag/taken       branch unit result and condition outcome
//   ex_target                JALR target rs1+imm
//   redirect_valid/pc/ready  fetch redirect handshake
//   ifq_flush                one-cycle fetch queue flush pulse
//   branch_solved            one-cycle pulse, branch resolved
//   jalr_solved              one-cycle pulse, JALR resolved
//   busy                     an instruction is pending
//   proto_err                sticky dispatch protocol violation flag
module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_branch,
  input  logic             disp_jalr,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic             ex_valid,
  input  logic [TAG_W-1:0] ex_tag,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             ifq_flush,
  output logic             branch_solved,
  output logic             jalr_solved,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BR   = 2'd1,
    WAIT_JALR = 2'd2,
    REDIRECT  = 2'd3
  } state_t;

  state_t           state;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  imm_q;
  logic             kind_jalr_q;   // 1: pending instruction is a JALR

  logic             ex_match;
  logic [XLEN-1:0]  jalr_mask;

  assign ex_match  = ex_valid && (ex_tag == tag_q);
  // JALR targets are forced to an even address by clearing bit 0.
  assign jalr_mask = {{(XLEN-1){1'b1}}, 1'b0};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      tag_q          <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      kind_jalr_q    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ifq_flush      <= 1'b0;
      branch_solved  <= 1'b0;
      jalr_solved    <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      // Pulse outputs fall back to 0 unless re-asserted below.
      ifq_flush     <= 1'b0;
      branch_solved <= 1'b0;
      jalr_solved   <= 1'b0;

      // Dispatch may only hand over a new instruction while idle.
      if ((state != IDLE) && (disp_branch || disp_jalr)) begin
        proto_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (disp_branch) begin
            tag_q       <= disp_tag;
            pc_q        <= disp_pc;
            imm_q       <= disp_imm;
            kind_jalr_q <= 1'b0;
            state       <= WAIT_BR;
            // A simultaneous JALR is dropped; the branch takes the slot.
            if (disp_jalr) begin
              proto_err <= 1'b1;
            end
          end else if (disp_jalr) begin
            tag_q       <= disp_tag;
            pc_q        <= disp_pc;
            imm_q       <= '0;
            kind_jalr_q <= 1'b1;
            state       <= WAIT_JALR;
          end
        end

        WAIT_BR: begin
          if (ex_match) begin
            if (ex_taken) begin
              redirect_pc    <= pc_q + imm_q;
              redirect_valid <= 1'b1;
              ifq_flush      <= 1'b1;
              state          <= REDIRECT;
            end else begin
              branch_solved  <= 1'b1;
              state          <= IDLE;
            end
          end
        end

        WAIT_JALR: begin
          if (ex_match) begin
            redirect_pc    <= ex_target & jalr_mask;
            redirect_valid <= 1'b1;
            ifq_flush      <= 1'b1;
            state          <= REDIRECT;
          end
        end

        REDIRECT: begin
          // redirect_valid is always 1 here, so ready alone completes it.
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            branch_solved  <= ~kind_jalr_q;
            jalr_solved    <= kind_jalr_q;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        disp_branch;
  logic        disp_jalr;
  logic [5:0]  disp_tag;
  logic [31:0] disp_pc;
  logic [31:0] disp_imm;
  logic        ex_valid;
  logic [5:0]  ex_tag;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        ifq_flush;
  logic        branch_solved;
  logic        jalr_solved;
  logic        busy;
  logic        proto_err;

  int tests_run;
  int tests_failed;

  branch_resolver #(.XLEN(32), .TAG_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp_branch   (disp_branch),
    .disp_jalr     (disp_jalr),
    .disp_tag      (disp_tag),
    .disp_pc       (disp_pc),
    .disp_imm      (disp_imm),
    .ex_valid      (ex_valid),
    .ex_tag        (ex_tag),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ready(redirect_ready),
    .ifq_flush     (ifq_flush),
    .branch_solved (branch_solved),
    .jalr_solved   (jalr_solved),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic fl,
                            input logic bs, input logic js, input logic bz);
    check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".ifq_flush"},      {31'd0, ifq_flush},      {31'd0, fl});
    check({tag, ".branch_solved"},  {31'd0, branch_solved},  {31'd0, bs});
    check({tag, ".jalr_solved"},    {31'd0, jalr_solved},    {31'd0, js});
    check({tag, ".busy"},           {31'd0, busy},           {31'd0, bz});
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b0;
    disp_branch    = 1'b0;
    disp_jalr      = 1'b0;
    disp_tag       = '0;
    disp_pc        = '0;
    disp_imm       = '0;
    ex_valid       = 1'b0;
    ex_tag         = '0;
    ex_taken       = 1'b0;
    ex_target      = '0;
    redirect_ready = 1'b0;

    // Reset state
    step(); step();
    check_outs("reset", 0, 0, 0, 0, 0);
    check("reset.redirect_pc", redirect_pc, 32'h0);
    check("reset.proto_err", {31'd0, proto_err}, 32'd0);
    rst = 1'b1;
    step();

    // Not-taken branch
    disp_branch = 1'b1; disp_tag = 6'd5; disp_pc = 32'h100; disp_imm = 32'h20;
    step();
    disp_branch = 1'b0;
    check_outs("nt.wait", 0, 0, 0, 0, 1);
    step();
    ex_valid = 1'b1; ex_tag = 6'd5; ex_taken = 1'b0;
    step();
    ex_valid = 1'b0;
    check_outs("nt.solved", 0, 0, 1, 0, 0);
    step();
    check_outs("nt.after", 0, 0, 0, 0, 0);

    // Taken branch with negative offset and three cycles of backpressure
    disp_branch = 1'b1; disp_tag = 6'd7; disp_pc = 32'h100; disp_imm = 32'hFFFF_FFF0;
    step();
    disp_branch = 1'b0;
    ex_valid = 1'b1; ex_tag = 6'd7; ex_taken = 1'b1; redirect_ready = 1'b0;
    step();
    ex_valid = 1'b0;
    check_outs("tk.c1", 1, 1, 0, 0, 1);
    check("tk.c1.pc", redirect_pc, 32'h0000_00F0);
    step();
    check_outs("tk.c2", 1, 0, 0, 0, 1);
    check("tk.c2.pc", redirect_pc, 32'h0000_00F0);
    step();
    check_outs("tk.c3", 1, 0, 0, 0, 1);
    check("tk.c3.pc", redirect_pc, 32'h0000_00F0);
    step();
    check_outs("tk.c4", 1, 0, 0, 0, 1);
    check("tk.c4.pc", redirect_pc, 32'h0000_00F0);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    check_outs("tk.solved", 0, 0, 1, 0, 0);
    step();
    check_outs("tk.after", 0, 0, 0, 0, 0);

    // JALR with odd target, ready already high
    disp_jalr = 1'b1; disp_tag = 6'd9; disp_pc = 32'h400;
    step();
    disp_jalr = 1'b0;
    check_outs("jalr.wait", 0, 0, 0, 0, 1);
    ex_valid = 1'b1; ex_tag = 6'd9; ex_taken = 1'b0; ex_target = 32'h2003;
    redirect_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    check_outs("jalr.redir", 1, 1, 0, 0, 1);
    check("jalr.pc", redirect_pc, 32'h2002);
    step();
    check_outs("jalr.solved", 0, 0, 0, 1, 0);
    step();
    redirect_ready = 1'b0;
    check_outs("jalr.after", 0, 0, 0, 0, 0);

    // Tag filtering
    disp_branch = 1'b1; disp_tag = 6'd3; disp_pc = 32'h200; disp_imm = 32'h10;
    step();
    disp_branch = 1'b0;
    ex_valid = 1'b1; ex_tag = 6'd4; ex_taken = 1'b1;
    step();
    check_outs("tag.other", 0, 0, 0, 0, 1);
    ex_tag = 6'd3; ex_taken = 1'b0;
    step();
    ex_valid = 1'b0;
    check_outs("tag.match", 0, 0, 1, 0, 0);

    // PC wrap-around on taken branch
    disp_branch = 1'b1; disp_tag = 6'd1; disp_pc = 32'hFFFF_FFFC; disp_imm = 32'h8;
    step();
    disp_branch = 1'b0;
    ex_valid = 1'b1; ex_tag = 6'd1; ex_taken = 1'b1; redirect_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    check_outs("wrap.redir", 1, 1, 0, 0, 1);
    check("wrap.pc", redirect_pc, 32'h0000_0004);
    step();
    redirect_ready = 1'b0;
    check_outs("wrap.solved", 0, 0, 1, 0, 0);
    check("wrap.proto_err", {31'd0, proto_err}, 32'd0);

    // Branch and JALR together: branch wins, proto_err set
    disp_branch = 1'b1; disp_jalr = 1'b1; disp_tag = 6'd2; disp_pc = 32'h500; disp_imm = 32'h4;
    step();
    disp_branch = 1'b0;
    check("both.proto_err", {31'd0, proto_err}, 32'd1);
    check_outs("both.wait", 0, 0, 0, 0, 1);
    // Extra JALR while busy is ignored
    disp_tag = 6'd11;
    step();
    disp_jalr = 1'b0;
    ex_valid = 1'b1; ex_tag = 6'd2; ex_taken = 1'b0;
    step();
    ex_valid = 1'b0;
    check_outs("both.solved", 0, 0, 1, 0, 0);
    check("both.proto_sticky", {31'd0, proto_err}, 32'd1);

    // Reset while a redirect is waiting for ready
    disp_branch = 1'b1; disp_tag = 6'd6; disp_pc = 32'h300; disp_imm = 32'h4;
    step();
    disp_branch = 1'b0;
    ex_valid = 1'b1; ex_tag = 6'd6; ex_taken = 1'b1; redirect_ready = 1'b0;
    step();
    ex_valid = 1'b0;
    check_outs("rr.redir", 1, 1, 0, 0, 1);
    check("rr.pc", redirect_pc, 32'h304);
    #2 rst = 1'b0;
    #1;
    check_outs("rr.async", 0, 0, 0, 0, 0);
    check("rr.async.pc", redirect_pc, 32'h0);
    check("rr.async.proto_err", {31'd0, proto_err}, 32'd0);
    step();
    rst = 1'b1;
    redirect_ready = 1'b1;
    step();
    check_outs("rr.post1", 0, 0, 0, 0, 0);
    step();
    redirect_ready = 1'b0;
    check_outs("rr.post2", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
